// File: rtl/conv_tile_sched.sv
// Tile scheduler for a 3x3 convolution followed by 2x2 max-pool (optional ReLU).
// Fetches 4x4 pixel tiles row by row, feeds an external conv datapath and streams pooled results.
module conv_tile_sched #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int RELU  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [71:0]         kernel_in,
   output logic                busy,
   output logic                done,
   output logic                mem_rd_en,
   output logic [15:0]         mem_rd_addr,
   input  logic [31:0]         mem_rd_data,
   output logic [127:0]        dp_image,
   output logic [71:0]         dp_kernel,
   input  logic [79:0]         dp_conv_out,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [19:0]  out_data,
   output logic [7:0]          out_row,
   output logic [7:0]          out_col
);

   typedef enum logic [2:0] {IDLE, FETCH, LAST, CALC, EMIT} state_t;

   localparam logic [15:0] W16    = 16'(IMG_W);
   localparam logic [7:0]  C_LAST = 8'(IMG_W - 4);
   localparam logic [7:0]  R_LAST = 8'(IMG_H - 4);

   state_t                r_state;
   state_t                w_next;
   logic [1:0]            r_k;
   logic [7:0]            r_r0;
   logic [7:0]            r_c0;
   logic                  r_rd_vld;
   logic [1:0]            r_rd_row;
   logic [3:0][31:0]      r_tile;
   logic [71:0]           r_kernel;
   logic                  r_done;
   logic signed [19:0]    r_out_data;
   logic [7:0]            r_out_row;
   logic [7:0]            r_out_col;

   logic                  w_hs;
   logic                  w_last_tile;
   logic [15:0]           w_row;
   logic signed [19:0]    w_max;
   logic signed [19:0]    w_result;

   assign w_hs        = (r_state == EMIT) && out_ready;
   assign w_last_tile = (r_r0 == R_LAST) && (r_c0 == C_LAST);
   assign w_row       = 16'(r_r0) + 16'(r_k);
   assign mem_rd_addr = w_row * W16 + 16'(r_c0);

   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: defaults first, so no path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      w_next    = r_state;
      busy      = (r_state != IDLE);
      mem_rd_en = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         IDLE:    if (start) w_next = FETCH;
         FETCH: begin
            mem_rd_en = 1'b1;
            if (r_k == 2'd3) w_next = LAST;
         end
         LAST:    w_next = CALC;
         CALC:    w_next = EMIT;
         EMIT: begin
            out_valid = 1'b1;
            if (out_ready) w_next = w_last_tile ? IDLE : FETCH;
         end
         default: w_next = IDLE;
      endcase
   end

   // Pool: signed max of the four conv outputs, then optional clamp at zero.
   always_comb begin
      w_max = $signed(dp_conv_out[19:0]);
      for (int i = 1; i < 4; i++) begin
         if ($signed(dp_conv_out[20*i +: 20]) > w_max) w_max = $signed(dp_conv_out[20*i +: 20]);
      end
      w_result = (RELU != 0 && w_max[19]) ? 20'sd0 : w_max;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_k        <= 2'd0;
         r_r0       <= 8'd0;
         r_c0       <= 8'd0;
         r_rd_vld   <= 1'b0;
         r_rd_row   <= 2'd0;
         // NOTE: the tile buffer is reset too, because dp_image must read 0 while in reset.
         r_tile     <= '0;
         r_kernel   <= '0;
         r_done     <= 1'b0;
         r_out_data <= '0;
         r_out_row  <= 8'd0;
         r_out_col  <= 8'd0;
      end else begin
         r_rd_vld <= mem_rd_en;
         r_rd_row <= r_k;
         if (r_rd_vld) r_tile[r_rd_row] <= mem_rd_data;
         if (r_state == IDLE && start) r_kernel <= kernel_in;
         if (r_state == FETCH) r_k <= r_k + 2'd1;
         if (r_state == CALC) begin
            r_out_data <= w_result;
            r_out_row  <= {1'b0, r_r0[7:1]};
            r_out_col  <= {1'b0, r_c0[7:1]};
         end
         r_done <= 1'b0;
         if (w_hs) begin
            if (w_last_tile) begin
               r_r0   <= 8'd0;
               r_c0   <= 8'd0;
               r_done <= 1'b1;
            end else if (r_c0 == C_LAST) begin
               r_c0 <= 8'd0;
               r_r0 <= r_r0 + 8'd2;
            end else begin
               r_c0 <= r_c0 + 8'd2;
            end
         end
      end
   end

   assign done      = r_done;
   assign dp_image  = r_tile;
   assign dp_kernel = r_kernel;
   assign out_data  = r_out_data;
   assign out_row   = r_out_row;
   assign out_col   = r_out_col;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Directed bench for conv_tile_sched: models pixel memory and the conv datapath,
// runs two instances (RELU=1 and RELU=0) side by side on identical stimulus.
module tb_conv_tile_sched;

   localparam logic [71:0] K_ONES   = {9{8'h01}};
   localparam logic [71:0] K_NEG    = {9{8'hFF}};
   localparam logic [71:0] K_MAX    = {9{8'h7F}};
   localparam logic [71:0] K_CENTRE = 72'h01 << 32;

   logic               clk;
   logic               rst_n;
   logic               start;
   logic [71:0]        kernel_in;
   logic               out_ready;

   logic               busy, done, mem_rd_en, out_valid;
   logic [15:0]        mem_rd_addr;
   logic [31:0]        mem_rd_data;
   logic [127:0]       dp_image;
   logic [71:0]        dp_kernel;
   logic [79:0]        dp_conv_out;
   logic signed [19:0] out_data;
   logic [7:0]         out_row, out_col;

   logic               busy0, done0, mem_rd_en0, out_valid0;
   logic [15:0]        mem_rd_addr0;
   logic [31:0]        mem_rd_data0;
   logic [127:0]       dp_image0;
   logic [71:0]        dp_kernel0;
   logic [79:0]        dp_conv_out0;
   logic signed [19:0] out_data0;
   logic [7:0]         out_row0, out_col0;

   int                 checks;
   int                 errors;
   int                 n_res;
   bit                 done_ok;
   bit                 timed_out;
   logic signed [19:0] res_data  [16];
   logic signed [19:0] res_data0 [16];
   logic [7:0]         res_row   [16];
   logic [7:0]         res_col   [16];
   logic [7:0]         mem       [64];

   conv_tile_sched #(.IMG_W(8), .IMG_H(8), .RELU(1)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .kernel_in(kernel_in),
      .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_data(mem_rd_data), .dp_image(dp_image), .dp_kernel(dp_kernel),
      .dp_conv_out(dp_conv_out), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_row(out_row), .out_col(out_col)
   );

   conv_tile_sched #(.IMG_W(8), .IMG_H(8), .RELU(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .kernel_in(kernel_in),
      .busy(busy0), .done(done0), .mem_rd_en(mem_rd_en0), .mem_rd_addr(mem_rd_addr0),
      .mem_rd_data(mem_rd_data0), .dp_image(dp_image0), .dp_kernel(dp_kernel0),
      .dp_conv_out(dp_conv_out0), .out_valid(out_valid0), .out_ready(out_ready),
      .out_data(out_data0), .out_row(out_row0), .out_col(out_col0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [15:0] a);
      int b;
      b = int'(a);
      return {mem[(b + 3) & 63], mem[(b + 2) & 63], mem[(b + 1) & 63], mem[b & 63]};
   endfunction

   always @(posedge clk) begin
      if (mem_rd_en)  mem_rd_data  <= mem_word(mem_rd_addr);
      if (mem_rd_en0) mem_rd_data0 <= mem_word(mem_rd_addr0);
   end

   // Reference conv: unsigned pixels, signed kernel tap (a,b) at byte 3a+b.
   function automatic logic [79:0] conv_model(input logic [127:0] img, input logic [71:0] ker);
      logic [79:0] res;
      int          acc;
      res = '0;
      for (int i = 0; i < 2; i++) begin
         for (int j = 0; j < 2; j++) begin
            acc = 0;
            for (int a = 0; a < 3; a++) begin
               for (int b = 0; b < 3; b++) begin
                  acc += int'(img[8*(4*(i+a) + j + b) +: 8]) * int'($signed(ker[8*(3*a + b) +: 8]));
               end
            end
            res[20*(2*i + j) +: 20] = acc[19:0];
         end
      end
      return res;
   endfunction

   assign dp_conv_out  = conv_model(dp_image, dp_kernel);
   assign dp_conv_out0 = conv_model(dp_image0, dp_kernel0);

   task automatic fill_const(input logic [7:0] v);
      for (int i = 0; i < 64; i++) mem[i] = v;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < 64; i++) mem[i] = 8'(i);
   endtask

   task automatic start_image(input logic [71:0] k);
      kernel_in = k;
      start     = 1'b1;
      @(negedge clk);
      start     = 1'b0;
      kernel_in = '0;
   endtask

   task automatic collect(input int budget);
      bit prev_hs;
      prev_hs   = 1'b0;
      n_res     = 0;
      done_ok   = 1'b0;
      timed_out = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if (done) begin
            done_ok   = prev_hs;
            timed_out = 1'b0;
            break;
         end
         prev_hs = out_valid && out_ready;
         if (prev_hs && n_res < 16) begin
            res_data[n_res]  = out_data;
            res_data0[n_res] = out_data0;
            res_row[n_res]   = out_row;
            res_col[n_res]   = out_col;
            n_res++;
         end
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; out_ready = 1'b0; kernel_in = '0;
      repeat (2) @(negedge clk);
      checks++;
      if ({busy, done, mem_rd_en, out_valid, out_data, out_row, out_col, mem_rd_addr} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: busy=%b done=%b en=%b valid=%b data=%0d row=%0d col=%0d addr=%0d, all required 0",
                  busy, done, mem_rd_en, out_valid, out_data, out_row, out_col, mem_rd_addr);
      end
      checks++;
      if ({dp_image, dp_kernel} !== '0) begin
         errors++;
         $display("FAIL reset_dp: image=%h kernel=%h, required 0", dp_image, dp_kernel);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || mem_rd_en !== 1'b0) begin
         errors++;
         $display("FAIL idle_no_start: busy=%b en=%b, required 0 0", busy, mem_rd_en);
      end
   endtask

   task automatic test_all_ones();
      fill_const(8'd1);
      out_ready = 1'b1;
      start_image(K_ONES);
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("FAIL busy_after_start: got %b required 1", busy);
      end
      collect(300);
      checks++;
      if (timed_out || n_res != 9 || !done_ok) begin
         errors++;
         $display("FAIL ones_count: results=%0d timeout=%b done_after_hs=%b, required 9 0 1", n_res, timed_out, done_ok);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (res_data[i] !== 20'sd9 || res_row[i] !== 8'(i / 3) || res_col[i] !== 8'(i % 3)) begin
            errors++;
            $display("FAIL ones_res%0d: data=%0d row=%0d col=%0d, required 9 %0d %0d",
                     i, res_data[i], res_row[i], res_col[i], i / 3, i % 3);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_at_done: got %b required 0", busy);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++;
         $display("FAIL done_pulse: got %b one cycle later, required 0", done);
      end
   endtask

   task automatic test_ramp();
      fill_ramp();
      out_ready = 1'b1;
      start_image(K_CENTRE);
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'(k * 8)) begin
            errors++;
            $display("FAIL fetch%0d: en=%b addr=%0d, required 1 %0d", k, mem_rd_en, mem_rd_addr, k * 8);
         end
         @(negedge clk);
      end
      for (int k = 0; k < 2; k++) begin
         checks++;
         if (mem_rd_en !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_fetch%0d: en=%b valid=%b, required 0 0", k, mem_rd_en, out_valid);
         end
         @(negedge clk);
      end
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL valid_latency: valid=%b 6 cycles after first read, required 1", out_valid);
      end
      collect(300);
      checks++;
      if (timed_out || n_res != 9 || !done_ok) begin
         errors++;
         $display("FAIL ramp_count: results=%0d timeout=%b done_after_hs=%b, required 9 0 1", n_res, timed_out, done_ok);
      end
      // Centre tap only: the pool max is pixel (r0+2, c0+2) = 8*(r0+2) + c0 + 2.
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (res_data[i] !== 20'(8 * (2 * (i / 3) + 2) + 2 * (i % 3) + 2)) begin
            errors++;
            $display("FAIL ramp_res%0d: data=%0d required %0d", i, res_data[i], 8 * (2 * (i / 3) + 2) + 2 * (i % 3) + 2);
         end
      end
   endtask

   task automatic test_relu();
      fill_const(8'd1);
      out_ready = 1'b1;
      start_image(K_NEG);
      collect(300);
      checks++;
      if (timed_out || n_res != 9) begin
         errors++;
         $display("FAIL relu_count: results=%0d timeout=%b, required 9 0", n_res, timed_out);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (res_data[i] !== 20'sd0 || res_data0[i] !== -20'sd9) begin
            errors++;
            $display("FAIL relu_res%0d: relu1=%0d relu0=%0d, required 0 -9", i, res_data[i], res_data0[i]);
         end
      end
   endtask

   task automatic test_overflow();
      fill_const(8'd255);
      out_ready = 1'b1;
      start_image(K_MAX);
      collect(300);
      checks++;
      if (timed_out || n_res != 9) begin
         errors++;
         $display("FAIL big_count: results=%0d timeout=%b, required 9 0", n_res, timed_out);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (res_data[i] !== 20'sd291465 || res_data0[i] !== 20'sd291465) begin
            errors++;
            $display("FAIL big_res%0d: relu1=%0d relu0=%0d, required 291465", i, res_data[i], res_data0[i]);
         end
      end
   endtask

   task automatic test_backpressure();
      fill_ramp();
      out_ready = 1'b0;
      start_image(K_CENTRE);
      for (int c = 0; c < 20 && out_valid !== 1'b1; c++) @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
         errors++;
         $display("FAIL bp_wait_valid: valid=%b after 20 cycles, required 1", out_valid);
      end
      for (int c = 0; c < 10; c++) begin
         checks++;
         if (out_valid !== 1'b1 || out_data !== 20'sd18 || out_row !== 8'd0 || out_col !== 8'd0 || mem_rd_en !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold%0d: valid=%b data=%0d row=%0d col=%0d en=%b, required 1 18 0 0 0",
                     c, out_valid, out_data, out_row, out_col, mem_rd_en);
         end
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (mem_rd_en !== 1'b1 || mem_rd_addr !== 16'd2 || out_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_resume: en=%b addr=%0d valid=%b, required 1 2 0", mem_rd_en, mem_rd_addr, out_valid);
      end
      collect(300);
      checks++;
      if (timed_out || n_res != 8 || !done_ok || res_data[0] !== 20'sd20 || res_data[7] !== 20'sd54) begin
         errors++;
         $display("FAIL bp_rest: results=%0d timeout=%b done_after_hs=%b first=%0d last=%0d, required 8 0 1 20 54",
                  n_res, timed_out, done_ok, res_data[0], res_data[7]);
      end
   endtask

   task automatic test_mid_reset();
      int hs;
      fill_const(8'd1);
      out_ready = 1'b1;
      start_image(K_ONES);
      start_image(K_NEG);
      checks++;
      if (dp_kernel !== K_ONES) begin
         errors++;
         $display("FAIL start_while_busy: kernel=%h required %h", dp_kernel, K_ONES);
      end
      hs = 0;
      for (int c = 0; c < 300; c++) begin
         if (hs == 4 && mem_rd_en === 1'b1) break;
         if (out_valid && out_ready) hs++;
         @(negedge clk);
      end
      checks++;
      if (hs != 4 || mem_rd_en !== 1'b1) begin
         errors++;
         $display("FAIL reach_tile4: handshakes=%0d en=%b, required 4 1", hs, mem_rd_en);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, mem_rd_en, out_valid, out_data, out_row, out_col, mem_rd_addr, dp_image, dp_kernel} !== '0) begin
         errors++;
         $display("FAIL async_reset: busy=%b en=%b valid=%b data=%0d row=%0d col=%0d image=%h kernel=%h, required 0",
                  busy, mem_rd_en, out_valid, out_data, out_row, out_col, dp_image, dp_kernel);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      start_image(K_ONES);
      collect(300);
      checks++;
      if (timed_out || n_res != 9 || !done_ok) begin
         errors++;
         $display("FAIL restart_count: results=%0d timeout=%b done_after_hs=%b, required 9 0 1", n_res, timed_out, done_ok);
      end
      for (int i = 0; i < 9; i++) begin
         checks++;
         if (res_data[i] !== 20'sd9 || res_row[i] !== 8'(i / 3) || res_col[i] !== 8'(i % 3)) begin
            errors++;
            $display("FAIL restart_res%0d: data=%0d row=%0d col=%0d, required 9 %0d %0d",
                     i, res_data[i], res_row[i], res_col[i], i / 3, i % 3);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_all_ones();
      test_ramp();
      test_relu();
      test_overflow();
      test_backpressure();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
